// File: rtl/ifft16_synth.sv
// 16-point inverse FFT: bins land in a two-bank ping-pong store and are synthesised
// into 16 natural-order real samples by a single multiply-accumulate datapath.
module ifft16_synth (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fft_data,
    input  logic        fft_valid,
    input  logic [3:0]  freq,
    input  logic        fft_fin,
    output logic [15:0] ifft_data,
    output logic        ifft_valid,
    output logic        ifft_fin,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    // cos(2*pi*m/16) in Q16; sin(m) is read as cos(m-4)
    localparam logic signed [19:0] TWIDDLE [16] = '{
        20'sh10000,  20'sh0EC83,  20'sh0B504,  20'sh061F7,
        20'sh00000, -20'sh061F7, -20'sh0B504, -20'sh0EC83,
        -20'sh10000, -20'sh0EC83, -20'sh0B504, -20'sh061F7,
        20'sh00000,  20'sh061F7,  20'sh0B504,  20'sh0EC83
    };

    state_t      state_reg, state_next;
    logic [3:0]  n_reg, n_next;
    logic [3:0]  k_reg, k_next;
    logic        rd_bank_reg, rd_bank_next;
    logic        wr_bank_reg;
    logic [1:0]  full_reg, full_soon, full_next;
    logic        release_bank;

    logic        wr_en, set_full, drop;
    logic [31:0] bank_mem [0:31];

    logic [4:0]  rd_addr;
    logic [3:0]  m_cos, m_sin;
    logic [31:0] x_reg;
    logic signed [19:0] cos_reg, sin_reg;
    logic signed [15:0] xr, xi;
    logic signed [35:0] pr_reg, pi_reg;
    logic        v1_reg, v2_reg;
    logic signed [39:0] acc_reg, acc_sum, rnd, shifted;
    logic [15:0] sat_val;
    logic        last_drain;

    // ---------------- write side ----------------
    assign wr_en    = fft_valid && !full_reg[wr_bank_reg];
    assign set_full = wr_en && fft_fin;
    assign drop     = fft_valid && full_reg[wr_bank_reg];

    always_ff @(posedge clk) begin
        if (wr_en)
            bank_mem[{wr_bank_reg, freq}] <= fft_data;
    end

    // full_soon includes a tag being set this cycle so the FSM can start without a bubble
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_tag
        assign full_soon[gi] = full_reg[gi] | (set_full && (wr_bank_reg == 1'(gi)));
        assign full_next[gi] = (release_bank && (rd_bank_reg == 1'(gi))) ? 1'b0 : full_soon[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (set_full)
                wr_bank_reg <= ~wr_bank_reg;
            if (drop)
                overrun <= 1'b1;
        end
    end

    // ---------------- compute FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            n_reg       <= '0;
            k_reg       <= '0;
            rd_bank_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            n_reg       <= n_next;
            k_reg       <= k_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        k_next       = k_reg;
        rd_bank_next = rd_bank_reg;
        release_bank = 1'b0;
        case (state_reg)
            IDLE: begin
                if (full_soon[rd_bank_reg]) begin
                    state_next = MAC;
                    n_next     = '0;
                    k_next     = '0;
                end
            end
            MAC: begin
                k_next = k_reg + 4'd1;
                if (k_reg == 4'd15) begin
                    state_next = DRAIN;
                    k_next     = '0;
                end
            end
            DRAIN: begin
                k_next = k_reg + 4'd1;
                if (k_reg == 4'd1) begin
                    state_next = OUT;
                    k_next     = '0;
                end
            end
            OUT: begin
                k_next = '0;
                if (n_reg != 4'd15) begin
                    state_next = MAC;
                    n_next     = n_reg + 4'd1;
                end else begin
                    release_bank = 1'b1;
                    rd_bank_next = ~rd_bank_reg;
                    n_next       = '0;
                    state_next   = full_soon[~rd_bank_reg] ? MAC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // ---------------- datapath ----------------
    assign rd_addr = {rd_bank_reg, k_reg};
    assign m_cos   = k_reg * n_reg;
    assign m_sin   = m_cos - 4'd4;

    always_ff @(posedge clk) begin
        x_reg   <= bank_mem[rd_addr];
        cos_reg <= TWIDDLE[m_cos];
        sin_reg <= TWIDDLE[m_sin];
        pr_reg  <= xr * cos_reg;
        pi_reg  <= xi * sin_reg;
    end

    assign xr = x_reg[31:16];
    assign xi = x_reg[15:0];

    assign acc_sum = acc_reg + {{4{pr_reg[35]}}, pr_reg} - {{4{pi_reg[35]}}, pi_reg};
    assign rnd     = acc_sum + 40'sd524288;
    assign shifted = rnd >>> 20;

    always_comb begin
        sat_val = shifted[15:0];
        if (shifted > 40'sd32767)
            sat_val = 16'h7FFF;
        else if (shifted < -40'sd32768)
            sat_val = 16'h8000;
    end

    // final product of a sample arrives in the second DRAIN cycle; it is folded straight into the output
    assign last_drain = (state_reg == DRAIN) && (k_reg == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg     <= 1'b0;
            v2_reg     <= 1'b0;
            acc_reg    <= '0;
            ifft_data  <= '0;
            ifft_valid <= 1'b0;
            ifft_fin   <= 1'b0;
        end else begin
            v1_reg <= (state_reg == MAC);
            v2_reg <= v1_reg;
            if (state_reg == MAC && k_reg == 4'd0)
                acc_reg <= '0;
            else if (v2_reg)
                acc_reg <= acc_sum;
            ifft_valid <= last_drain;
            ifft_fin   <= last_drain && (n_reg == 4'd15);
            if (last_drain)
                ifft_data <= sat_val;
        end
    end

endmodule

// File: tb/tb_ifft16_synth.sv
// Randomised and directed bench for ifft16_synth; expected samples come from a
// direct DFT over a model of the two bin banks.
module tb_ifft16_synth;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fft_data = '0;
    logic        fft_valid = 1'b0;
    logic [3:0]  freq = '0;
    logic        fft_fin = 1'b0;
    logic [15:0] ifft_data;
    logic        ifft_valid;
    logic        ifft_fin;
    logic        overrun;
    logic        busy;

    ifft16_synth dut (
        .clk       (clk),
        .rst       (rst),
        .fft_data  (fft_data),
        .fft_valid (fft_valid),
        .freq      (freq),
        .fft_fin   (fft_fin),
        .ifft_data (ifft_data),
        .ifft_valid(ifft_valid),
        .ifft_fin  (ifft_fin),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // bank model and frame staging
    int mdl_re [2][16];
    int mdl_im [2][16];
    int mdl_wr = 0;
    int fr_re [16];
    int fr_im [16];

    int exp_q [$];
    int got_q [$];
    int gotfin_q [$];
    int gotcyc_q [$];

    always @(negedge clk) begin
        if (ifft_valid) begin
            got_q.push_back(int'($signed(ifft_data)));
            gotfin_q.push_back(int'(ifft_fin));
            gotcyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] bitrev(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic longint cos_q16(input int m_in);
        longint mag [5] = '{65536, 60547, 46340, 25079, 0};
        int m = m_in & 15;
        if (m <= 4)  return mag[m];
        if (m <= 8)  return -mag[8 - m];
        if (m <= 12) return -mag[m - 8];
        return mag[16 - m];
    endfunction

    function automatic int ref_sample(input int b, input int n);
        longint acc = 0;
        longint r;
        for (int k = 0; k < 16; k++) begin
            int m = (k * n) % 16;
            acc += longint'(mdl_re[b][k]) * cos_q16(m) - longint'(mdl_im[b][k]) * cos_q16(m + 12);
        end
        r = (acc + 524288) >>> 20;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic set_single(input int k, input int re, input int im);
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
        fr_re[k] = re;
        fr_im[k] = im;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // Sends nbins bins (bit-reversed or shuffled order); fcyc is the cycle carrying fft_fin.
    task automatic send_frame(input int nbins, input bit shuffle, input bit accepted,
                              input bit want_out, output int fcyc);
        int order [16];
        int b;
        for (int i = 0; i < 16; i++) order[i] = int'(bitrev(4'(i)));
        if (shuffle) begin
            for (int i = 15; i > 0; i--) begin
                int j = int'($urandom_range(0, i));
                int t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
        end
        fcyc = -1;
        for (int i = 0; i < nbins; i++) begin
            int k = order[i];
            fft_valid = 1'b1;
            freq      = 4'(k);
            fft_data  = {fr_re[k][15:0], fr_im[k][15:0]};
            fft_fin   = (i == nbins - 1);
            if (i == nbins - 1) fcyc = cyc;
            tick(1);
        end
        fft_valid = 1'b0;
        fft_fin   = 1'b0;
        if (accepted) begin
            b = mdl_wr;
            for (int i = 0; i < nbins; i++) begin
                mdl_re[b][order[i]] = fr_re[order[i]];
                mdl_im[b][order[i]] = fr_im[order[i]];
            end
            mdl_wr ^= 1;
            if (want_out)
                for (int n = 0; n < 16; n++) exp_q.push_back(ref_sample(b, n));
        end
    endtask

    task automatic drain(input int nsamp, input string tag, output int first_cyc);
        int budget = 19 * nsamp + 400;
        int c = 0;
        int prev = -1;
        while (got_q.size() < nsamp && c < budget) begin
            tick(1);
            c++;
        end
        if (got_q.size() < nsamp)
            check({tag, " timeout"}, got_q.size(), nsamp);
        first_cyc = -1;
        for (int i = 0; i < nsamp; i++) begin
            int d, f, cy, e;
            if (got_q.size() == 0 || exp_q.size() == 0) break;
            d  = got_q.pop_front();
            f  = gotfin_q.pop_front();
            cy = gotcyc_q.pop_front();
            e  = exp_q.pop_front();
            $display("%s sample %0d: x=%0d ref=%0d fin=%0d cycle=%0d", tag, i, d, e, f, cy);
            check({tag, " data"}, d, e);
            check({tag, " fin"}, f, ((i % 16) == 15) ? 1 : 0);
            if (i == 0) first_cyc = cy;
            else check({tag, " spacing"}, cy - prev, 19);
            prev = cy;
        end
    endtask

    initial begin
        int f, fa, fc, nb;

        tick(3);
        check("reset ifft_data", ifft_data, 0);
        check("reset ifft_valid", ifft_valid, 0);
        check("reset ifft_fin", ifft_fin, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // DC frame
        set_single(0, 4096, 0);
        send_frame(16, 1'b0, 1'b1, 1'b1, f);
        check("dc busy", busy, 1);
        drain(16, "dc", fc);
        check("dc first strobe", fc, f + 19);
        check("dc idle busy", busy, 0);

        // single cosine on bin 1
        set_single(1, 8192, 0);
        send_frame(16, 1'b0, 1'b1, 1'b1, f);
        drain(16, "cos", fc);
        check("cos first strobe", fc, f + 19);

        // imaginary bin 4
        set_single(4, 0, -8192);
        send_frame(16, 1'b0, 1'b1, 1'b1, f);
        drain(16, "imag", fc);

        // random frames, shuffled order, some partial (unwritten bins keep old contents)
        for (int r = 0; r < 6; r++) begin
            set_random();
            nb = (r < 2) ? 16 : int'($urandom_range(1, 16));
            send_frame(nb, 1'b1, 1'b1, 1'b1, f);
            drain(16, "rand", fc);
            check("rand first strobe", fc, f + 19);
        end

        // ping-pong: two frames back to back, continuous output
        set_single(0, 4096, 0);
        send_frame(16, 1'b0, 1'b1, 1'b1, fa);
        set_single(0, 8192, 0);
        send_frame(16, 1'b0, 1'b1, 1'b1, f);
        drain(32, "pingpong", fc);
        check("pingpong first strobe", fc, fa + 19);
        check("pingpong overrun", overrun, 0);

        // overrun: third back-to-back frame finds both banks full
        set_random();
        send_frame(16, 1'b1, 1'b1, 1'b1, f);
        set_random();
        send_frame(16, 1'b1, 1'b1, 1'b1, f);
        check("overrun before third", overrun, 0);
        set_random();
        send_frame(16, 1'b1, 1'b0, 1'b0, f);
        check("overrun set", overrun, 1);
        drain(32, "overrun", fc);
        tick(400);
        check("overrun extra samples", got_q.size(), 0);
        check("overrun sticky", overrun, 1);

        // reset during MAC of n=5
        set_single(0, 4096, 0);
        send_frame(16, 1'b0, 1'b1, 1'b0, f);
        tick(f + 100 - cyc);
        check("pre-reset samples", got_q.size(), 5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst ifft_data", ifft_data, 0);
        check("midrst ifft_valid", ifft_valid, 0);
        check("midrst ifft_fin", ifft_fin, 0);
        check("midrst overrun", overrun, 0);
        check("midrst busy", busy, 0);
        got_q.delete();
        gotfin_q.delete();
        gotcyc_q.delete();
        mdl_wr = 0;
        tick(400);
        check("post-reset strobes", got_q.size(), 0);

        set_single(0, 4096, 0);
        send_frame(16, 1'b0, 1'b1, 1'b1, f);
        drain(16, "after-reset dc", fc);
        check("after-reset first strobe", fc, f + 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifft16_synth.md
# ifft16_synth

16-point inverse FFT that consumes the bit-reversed complex bin stream produced by the forward FFT stage and emits 16 real time-domain samples per frame in natural order. It sits at the synthesis end of the voice-processing path, after spectral modification, and feeds the sample-rate output/DAC path. Frames are buffered in a two-bank ping-pong store so the next frame can be written while the current one is being synthesised.

## Interface
Parameters:
- none; the transform size N=16 is fixed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fft_data  in  32  bin value: {re[15:0], im[15:0]}, each signed two's complement.
- fft_valid  in  1  bin strobe; fft_data/freq are valid this cycle.
- freq  in  4  bin index k (0..15), any order; bit-reversed order is the normal case.
- fft_fin  in  1  last bin of the frame; qualified by fft_valid.
- ifft_data  out  16  signed real sample x[n].
- ifft_valid  out  1  one-cycle strobe per output sample.
- ifft_fin  out  1  high with ifft_valid for n=15.
- overrun  out  1  sticky; set when a bin is dropped, cleared only by rst.
- busy  out  1  high while a frame is being synthesised.

## Operation
- Banks: two 16x32 RAMs, each tagged EMPTY/FULL. wr_bank and rd_bank pointers are both 0 after reset.
- Write: on fft_valid, if bank[wr_bank] is EMPTY, write fft_data at address freq. If fft_fin is also set, tag the bank FULL and toggle wr_bank. If bank[wr_bank] is FULL, drop the bin and set overrun.
- Missing bins are not zeroed: bins not written since the bank was last read keep their old contents. RAM contents are not cleared by rst.
- Compute FSM states: IDLE, MAC, DRAIN, OUT.
  - IDLE -> MAC when bank[rd_bank] is FULL; n=0.
  - MAC: 16 cycles, k=0..15. Read X[k] and twiddle index m=(k*n) mod 16, both with registered reads.
  - DRAIN: 2 cycles to flush the multiply and accumulate pipeline.
  - OUT: 1 cycle; the output register is loaded.
  - OUT -> MAC for n+1 when n<15.
  - After n=15: tag bank[rd_bank] EMPTY and toggle rd_bank. Go to MAC (n=0) if the new bank is FULL, otherwise IDLE.
- Arithmetic: x[n] = (1/16)·Σ (Xr·cos θ − Xi·sin θ), with θ=2πm/16.
  - Twiddle ROM is 20-bit signed Q16, 1.0=0x10000. Cos magnitudes for m=0..3 are 0x10000, 0x0EC83, 0x0B504, 0x061F7. sin(m)=cos(m−4).
  - Products are 36 bits; the accumulator is 40-bit signed and cleared at the start of each n.
  - Result = (acc + 2^19) >>> 20, saturated to [−32768, 32767].
- busy is high in MAC/DRAIN/OUT.
- Simultaneous events:
  - A bank going FULL in the same cycle the other bank is released: both updates take effect. The FSM enters MAC the next cycle.
  - A write to a bank in the same cycle it is released: the write is dropped and sets overrun, because the EMPTY tag takes effect only on the following edge.
- Reset mid-operation: FSM to IDLE, both banks EMPTY, both pointers 0, all outputs 0. A partially written frame is discarded.

## Timing
- Reset values: ifft_data=0, ifft_valid=0, ifft_fin=0, overrun=0, busy=0.
- Let F be the cycle in which fft_valid&fft_fin is sampled and the FSM is IDLE.
  - MAC runs cycles F+1..F+16, DRAIN F+17..F+18.
  - ifft_valid for n=0 is high in cycle F+19.
  - Sample n is valid in cycle F+19+19n. The last sample (ifft_fin) is at F+304.
- Frame service time is 304 cycles.
- Input bins may arrive on consecutive cycles. A new frame must not complete while both banks are FULL.
- ifft_data holds its value between strobes.

## Test plan
- DC: X[0]=(4096,0), all other bins 0, delivered in bit-reversed order -> 16 samples of 256; ifft_fin only on the 16th; first strobe at F+19.
- Single cosine: X[1]=(8192,0), rest 0 -> x[0]=512, x[2]=362, x[4]=0, x[8]=−512, x[12]=0.
- Imaginary bin: X[4]=(0,−8192), rest 0 -> x[0]=0, x[1]=512, x[2]=0, x[3]=−512, repeating with period 4.
- Ping-pong: frame A (DC 4096), then frame B (DC 8192) immediately after -> 16×256 then 16×512 with no IDLE gap; ifft_valid spacing stays 19 cycles; overrun=0.
- Overrun: three back-to-back frames with no gap -> all bins of the third frame dropped, overrun=1 and sticky; frames 1 and 2 output correctly.
- Reset mid-frame: assert rst for 1 cycle during MAC of n=5 -> all outputs 0 next cycle, no further strobes; a fresh DC frame afterwards produces a normal 16-sample output.
